mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, memory byte-address width.
REQ-002 Parameter: LATENCY, default 4, cycles the memory port is held per access (legal range 1..15).
REQ-003 Parameter: STARVE_MAX, default 3, consecutive lost arbitrations after which the instruction side wins.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_req  in  1  instruction-side read request, level, held until if_valid.
REQ-007 if_addr  in  ADDR_WIDTH  instruction-side byte address.
REQ-008 if_data  out  16  instruction read data, valid with if_valid.
REQ-009 if_valid  out  1  one-cycle completion pulse for the instruction side.
REQ-010 d_req  in  1  data-side request, level, held until d_valid.
REQ-011 d_wr  in  1  data-side write (1) / read (0).
REQ-012 d_addr  in  ADDR_WIDTH  data-side byte address.
REQ-013 d_wdata  in  16  data-side write data.
REQ-014 d_rdata  out  16  data read data, valid with d_valid.
REQ-015 d_valid  out  1  one-cycle completion pulse for the data side, reads and writes.
REQ-016 mem_enable, mem_wr  out  1 each  shared memory port controls.
REQ-017 mem_addr  out  ADDR_WIDTH  memory byte address, bit 0 always 0.
REQ-018 mem_data_in  out  16, mem_data_out  in  16  memory write and read data.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-021 IDLE: with any request pending, SHALL grant one requester, latch its address, wr and wdata, load the counter with LATENCY-1, then enter ACCESS; otherwise it SHALL stay in IDLE.
REQ-022 Priority SHALL go to the D-side, except that the I-side SHALL win when its starvation count equals STARVE_MAX.
REQ-023 The starvation count SHALL increment on each IDLE grant to D while if_req is high, and SHALL clear on any grant to I.
REQ-024 ACCESS: mem_enable SHALL be 1 and mem_addr SHALL be {latched_addr[ADDR_WIDTH-1:1],0}; the counter SHALL decrement each cycle and the FSM SHALL move to RESP after the cycle in which the counter is 0.
REQ-025 mem_wr SHALL be 1 only in the final ACCESS cycle of a write, so each write occurs exactly once.
REQ-026 On a read, mem_data_out SHALL be registered into if_data or d_rdata on the edge that leaves ACCESS.
REQ-027 RESP: the granted side's valid SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-028 Latency: valid SHALL assert LATENCY+1 cycles after the IDLE edge that grants; one access SHALL complete per LATENCY+2 cycles.
REQ-029 A requester dropping req during ACCESS SHALL NOT abort the access, and its valid SHALL still pulse.
REQ-030 Input changes after the grant SHALL have no effect on the access in progress.
REQ-031 if_data and d_rdata SHALL hold their last value until the next read for the same side completes.
REQ-032 Outside ACCESS, mem_enable, mem_wr, mem_addr and mem_data_in SHALL be 0.

Reset
REQ-033 rst SHALL immediately force IDLE, counter 0, starvation count 0, all valids 0, mem_enable 0, mem_wr 0, busy 0, and if_data, d_rdata and mem_addr to 0.
REQ-034 rst asserted during ACCESS SHALL discard the access: no valid pulse and no memory write.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), the grant-side enum (GNT_I, GNT_D) and the default LATENCY/STARVE_MAX constants.
REQ-036 The block SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification (LATENCY=4, STARVE_MAX=3)
REQ-037 Memory word 0xABCD at byte address 0x0010; I read of 0x0010 -> if_valid exactly 5 cycles after the grant edge, if_data = 0xABCD.
REQ-038 D write of 0x1234 to 0x0020, then I read of 0x0020 -> mem_wr high exactly 1 cycle, d_valid pulses, if_data = 0x1234.
REQ-039 if_req and d_req both raised in the same cycle -> D served first, I granted on the next IDLE, two valid pulses 6 cycles apart.
REQ-040 d_req held high continuously with if_req high -> three D grants, then the fourth grant goes to I.
REQ-041 rst pulsed in the 2nd ACCESS cycle of a write -> mem_enable drops in the same cycle, no d_valid, target word unchanged.
REQ-042 D read of odd address 0x0033 -> mem_addr = 0x0032 throughout ACCESS.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default timing constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam int DEF_LATENCY    = 4;
    localparam int DEF_STARVE_MAX = 3;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one 16-bit memory port between instruction and data requesters; D wins unless I has starved.
// Valid pulses LATENCY+1 cycles after the grant edge; one access per LATENCY+2 cycles; requests hold until valid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [15:0]           if_data,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_valid,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out,
    output logic                  busy
);

    localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [3:0]      CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [ADDR_WIDTH-1:0] EVEN_MASK = ~(ADDR_WIDTH'(1));

    state_t                state_q, state_d;
    gnt_t                  gnt_q, gnt_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           if_data_q, if_data_d;
    logic [15:0]           d_rdata_q, d_rdata_d;
    logic                  last_cycle;
    logic                  pick_i;

    assign last_cycle = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign pick_i     = if_req && (!d_req || (starve_q == STARVE_LIM));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    if (pick_i) begin
                        gnt_d    = GNT_I;
                        addr_d   = if_addr;
                        wr_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        gnt_d   = GNT_D;
                        addr_d  = d_addr;
                        wr_d    = d_wr;
                        wdata_d = d_wdata;
                        if (if_req) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    // Read data is captured on the same edge that leaves ACCESS.
                    if (!wr_q) begin
                        if (gnt_q == GNT_I) begin
                            if_data_d = mem_data_out;
                        end else begin
                            d_rdata_d = mem_data_out;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            cnt_q     <= '0;
            starve_q  <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Port controls decode from registered state so reset silences them immediately.
    assign mem_enable  = (state_q == ACCESS);
    assign mem_wr      = last_cycle && wr_q;
    assign mem_addr    = mem_enable ? (addr_q & EVEN_MASK) : '0;
    assign mem_data_in = mem_enable ? wdata_q : '0;
    assign busy        = (state_q != IDLE);
    assign if_valid    = (state_q == RESP) && (gnt_q == GNT_I);
    assign d_valid     = (state_q == RESP) && (gnt_q == GNT_D);
    assign if_data     = if_data_q;
    assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-order reference model and a word memory.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int LAT  = 4;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_wr;
    logic [AW-1:0] if_addr, d_addr;
    logic [15:0]   d_wdata;
    logic [15:0]   if_data, d_rdata;
    logic          if_valid, d_valid;
    logic          mem_enable, mem_wr, busy;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data_in, mem_data_out;

    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory attached to the port: combinational read, write on the clock edge.
    logic [15:0] mem_arr [0:32767];
    logic        pre_en;
    logic [14:0] pre_idx;
    logic [15:0] pre_val;
    assign mem_data_out = mem_arr[mem_addr[15:1]];
    always @(posedge clk) begin
        if (pre_en) mem_arr[pre_idx] <= pre_val;
        else if (mem_enable && mem_wr) mem_arr[mem_addr[15:1]] <= mem_data_in;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state: contents of the used window and arbitration history.
    logic [15:0] ref_mem [0:127];
    int          starve_m;
    logic [15:0] last_if, last_d;

    typedef struct {
        bit          side_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    bit   obs_side[$];

    bit          r_do_i;
    logic [15:0] r_i_addr;
    int          r_nd;
    bit          r_d_wr   [4];
    logic [15:0] r_d_addr [4];
    logic [15:0] r_d_wd   [4];

    // Grant order: D while it is asking unless I has lost SMAX times in a row.
    task automatic build_expect();
        int di = 0;
        int k  = 0;
        bit ip = r_do_i;
        exp_t e;
        while (ip || di < r_nd) begin
            if (di < r_nd && !(ip && starve_m == SMAX)) begin
                e.side_d = 1'b1;
                e.wr     = r_d_wr[di];
                e.addr   = r_d_addr[di];
                if (e.wr) begin
                    ref_mem[e.addr[7:1]] = r_d_wd[di];
                    e.data = r_d_wd[di];
                end else begin
                    e.data = ref_mem[e.addr[7:1]];
                end
                if (ip) starve_m++;
                di++;
            end else begin
                e.side_d = 1'b0;
                e.wr     = 1'b0;
                e.addr   = r_i_addr;
                e.data   = ref_mem[r_i_addr[7:1]];
                starve_m = 0;
                ip       = 1'b0;
            end
            e.cyc = k * (LAT + 2) + LAT + 1;
            k++;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_d(input int i);
        d_wr    = r_d_wr[i];
        d_addr  = r_d_addr[i];
        d_wdata = r_d_wd[i];
    endtask

    // Entered at a falling edge with the arbiter idle; leaves it idle at a falling edge.
    task automatic run_round();
        int   d_idx = 0;
        int   cyc = 0;
        int   en_cnt = 0;
        int   wr_cnt = 0;
        int   exp_wr = 0;
        int   budget;
        exp_t e;
        obs_side.delete();
        build_expect();
        foreach (exp_q[i]) if (exp_q[i].wr) exp_wr++;
        budget = exp_q.size() * (LAT + 2) + 10;
        if_req  = r_do_i;
        if_addr = r_i_addr;
        if (r_nd > 0) begin
            d_req = 1'b1;
            drive_d(0);
        end
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (mem_enable && exp_q.size() > 0) begin
                en_cnt++;
                check_eq("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr & 16'hFFFE));
                check_eq("mem_wr", 32'(mem_wr), 32'(exp_q[0].wr && en_cnt == LAT));
                if (mem_wr) wr_cnt++;
                if (exp_q[0].wr) check_eq("mem_data_in", 32'(mem_data_in), 32'(exp_q[0].data));
                // Anything the granted side does after the grant must be ignored.
                if (exp_q[0].side_d) begin
                    d_addr  = 16'($urandom);
                    d_wdata = 16'($urandom);
                    d_wr    = 1'($urandom);
                    d_req   = 1'($urandom);
                end else begin
                    if_addr = 16'($urandom);
                    if_req  = 1'($urandom);
                end
            end else begin
                check_eq("idle_port", 32'({mem_wr, mem_addr, mem_data_in}), 32'd0);
            end
            if (if_valid || d_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_valid", 32'({if_valid, d_valid}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    obs_side.push_back(d_valid);
                    check_eq("valid_side", 32'({if_valid, d_valid}), e.side_d ? 32'd1 : 32'd2);
                    check_eq("valid_cyc", 32'(cyc), 32'(e.cyc));
                    check_eq("access_len", 32'(en_cnt), 32'(LAT));
                    en_cnt = 0;
                    if (!e.wr) begin
                        if (e.side_d) last_d = e.data;
                        else          last_if = e.data;
                    end
                    check_eq("if_data", 32'(if_data), 32'(last_if));
                    check_eq("d_rdata", 32'(d_rdata), 32'(last_d));
                    if (e.side_d) begin
                        d_idx++;
                        if (d_idx < r_nd) begin
                            d_req = 1'b1;
                            drive_d(d_idx);
                        end else begin
                            d_req = 1'b0;
                        end
                    end else begin
                        if_req = 1'b0;
                    end
                end
            end
        end
        if (exp_q.size() > 0) begin
            check_eq("round_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check_eq("mem_wr_count", 32'(wr_cnt), 32'(exp_wr));
        @(negedge clk);
        check_eq("idle_busy", 32'({busy, if_valid, d_valid}), 32'd0);
    endtask

    task automatic set_round(input bit do_i, input logic [15:0] ia, input int nd);
        r_do_i   = do_i;
        r_i_addr = ia;
        r_nd     = nd;
        for (int i = 0; i < 4; i++) begin
            r_d_wr[i]   = 1'($urandom);
            r_d_addr[i] = 16'($urandom_range(0, 255));
            r_d_wd[i]   = 16'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        pre_en = 1'b1; pre_idx = '0; pre_val = '0;
        starve_m = 0; last_if = '0; last_d = '0;

        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            pre_idx = 15'(i);
            pre_val = (i == 8) ? 16'hABCD : 16'($urandom);
            ref_mem[i] = pre_val;
        end
        @(negedge clk);
        pre_en = 1'b0;
        check_eq("rst_ctrl", 32'({busy, if_valid, d_valid, mem_enable, mem_wr}), 32'd0);
        check_eq("rst_data", 32'({if_data, d_rdata}), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        // Instruction read of a preloaded word.
        set_round(1'b1, 16'h0010, 0);
        run_round();
        check_eq("i_read_abcd", 32'(if_data), 32'h0000ABCD);

        // Data write followed by an instruction read of the same word.
        set_round(1'b0, 16'h0000, 1);
        r_d_wr[0] = 1'b1; r_d_addr[0] = 16'h0020; r_d_wd[0] = 16'h1234;
        run_round();
        set_round(1'b1, 16'h0020, 0);
        run_round();
        check_eq("i_read_1234", 32'(if_data), 32'h00001234);

        // Simultaneous requests: D first, I on the next idle slot.
        set_round(1'b1, 16'h0030, 1);
        r_d_wr[0] = 1'b0; r_d_addr[0] = 16'h0010;
        run_round();
        check_eq("both_first_d", 32'(obs_side.size() > 0 ? obs_side[0] : 1'b0), 32'd1);

        // Continuous D traffic: three D grants then I breaks through.
        set_round(1'b1, 16'h0044, 4);
        run_round();
        check_eq("starve_order", 32'({obs_side.size() > 3 ? obs_side[0] : 1'b0,
                                      obs_side.size() > 3 ? obs_side[1] : 1'b0,
                                      obs_side.size() > 3 ? obs_side[2] : 1'b0,
                                      obs_side.size() > 3 ? obs_side[3] : 1'b1}), 32'hE);

        // Odd data address is presented word-aligned.
        set_round(1'b0, 16'h0000, 1);
        r_d_wr[0] = 1'b0; r_d_addr[0] = 16'h0033;
        run_round();

        // Reset in the second access cycle of a write discards it.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5555;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_pre_enable", 32'(mem_enable), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_access", 32'({busy, mem_enable, mem_wr, d_valid}), 32'd0);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        starve_m = 0; last_if = '0; last_d = '0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            check_eq("rst_no_valid", 32'({d_valid, mem_wr}), 32'd0);
        end
        check_eq("rst_no_write", 32'(mem_arr[32]), 32'(ref_mem[32]));
        check_eq("rst_clear_data", 32'({if_data, d_rdata}), 32'd0);

        // Random traffic mixes.
        for (int n = 0; n < 40; n++) begin
            bit di;
            int nd;
            di = 1'($urandom);
            nd = int'($urandom_range(0, 4));
            if (!di && nd == 0) nd = 1;
            set_round(di, 16'($urandom_range(0, 255)), nd);
            run_round();
        end

        for (int i = 0; i < 128; i++) begin
            check_eq("final_mem", 32'(mem_arr[i]), 32'(ref_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
